phase2dec: RTL and testbench

Phase-2 (decode) stage of the SIMPLE pipeline. Holds the IF/ID instruction register and decodes the held instruction into the control bundle consumed by the phase-3 control register. Also detects load-use hazards, applies branch flushes and latches HLT. Fetch is frozen through `hold` whenever a stall or halt is active.

---
 rtl/phase2dec.sv | 270 +++++++++++++++++++++++++++
 tb/tb_phase2dec.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase2dec.sv
// phase2dec: decode stage of the SIMPLE pipeline.
// Holds the IF/ID instruction register (IR, IRpc, IRv) and decodes the held
// instruction into the control bundle for the phase-3 control register.
// Also detects load-use hazards, applies branch flushes and latches HLT.
// Fetch is frozen through `hold` while a stall or halt is active.
module phase2dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inst,
    input  logic [15:0] pc_in,
    input  logic        inst_valid,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [2:0]  ex_rd,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic        ALUorshifter,
    output logic        AS_BC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        SLI,
    output logic [2:0]  Ra,
    output logic [2:0]  Rb,
    output logic [3:0]  opcode,
    output logic [7:0]  imm,
    output logic        br_en,
    output logic [2:0]  br_cond,
    output logic [15:0] pc_out,
    output logic        dvalid,
    output logic        hold,
    output logic        halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [15:0] ir_r;
    logic [15:0] irpc_r;
    logic        irv_r;
    logic [0:0]  state_r;

    logic        stall_s;
    logic        bubble_s;
    logic        is_hlt_s;
    logic        use_ra_s;
    logic        use_rb_s;

    // Raw (unmasked) decode of IR
    logic        alusrc1_s;
    logic        alusrc2_s;
    logic        shifter_s;
    logic        as_bc_s;
    logic        memread_s;
    logic        memwrite_s;
    logic        regwrite_s;
    logic        sli_s;
    logic [3:0]  opcode_s;
    logic [7:0]  imm_s;
    logic        br_en_s;
    logic [2:0]  br_cond_s;

    logic [1:0]  op1_s;
    logic [2:0]  op2_s;
    logic [3:0]  op3_s;

    assign op1_s = ir_r[15:14];
    assign op2_s = ir_r[13:11];
    assign op3_s = ir_r[7:4];

    // Combinational field decode of the held instruction plus its source-register usage.
    always_comb begin
        alusrc1_s  = 1'b0;
        alusrc2_s  = 1'b0;
        shifter_s  = 1'b0;
        as_bc_s    = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        sli_s      = 1'b0;
        opcode_s   = 4'b0000;
        imm_s      = 8'h00;
        br_en_s    = 1'b0;
        br_cond_s  = 3'b000;
        use_ra_s   = 1'b0;
        use_rb_s   = 1'b0;
        case (op1_s)
            2'b11: begin
                case (op3_s)
                    4'b0000, 4'b0001: begin   // ADD, SUB
                        alusrc1_s  = 1'b1;
                        as_bc_s    = 1'b1;
                        regwrite_s = 1'b1;
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_ra_s   = 1'b1;
                        use_rb_s   = 1'b1;
                    end
                    4'b0010, 4'b0011, 4'b0100: begin   // AND, OR, XOR
                        alusrc1_s  = 1'b1;
                        regwrite_s = 1'b1;
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_ra_s   = 1'b1;
                        use_rb_s   = 1'b1;
                    end
                    4'b0101: begin   // CMP: flags only, no write-back
                        alusrc1_s  = 1'b1;
                        as_bc_s    = 1'b1;
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_ra_s   = 1'b1;
                        use_rb_s   = 1'b1;
                    end
                    4'b0110: begin   // MOV: zero + r[Ra] through the adder
                        as_bc_s    = 1'b1;
                        regwrite_s = 1'b1;
                        opcode_s   = 4'b0000;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_ra_s   = 1'b1;
                    end
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: begin   // shifts of r[Rb] by d
                        alusrc1_s  = 1'b1;
                        shifter_s  = 1'b1;
                        regwrite_s = 1'b1;
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_rb_s   = 1'b1;
                    end
                    4'b1100: begin   // IN: reads no register
                        regwrite_s = 1'b1;
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                    end
                    4'b1101: begin   // OUT: reads Ra
                        opcode_s   = op3_s;
                        imm_s      = {4'b0000, ir_r[3:0]};
                        use_ra_s   = 1'b1;
                    end
                    default: begin   // HLT and reserved codes carry no control
                        opcode_s   = 4'b0000;
                    end
                endcase
            end
            2'b00: begin   // LD r[Ra] <- mem[r[Rb] + d]
                alusrc1_s  = 1'b1;
                alusrc2_s  = 1'b1;
                as_bc_s    = 1'b1;
                memread_s  = 1'b1;
                regwrite_s = 1'b1;
                imm_s      = ir_r[7:0];
                use_rb_s   = 1'b1;
            end
            2'b01: begin   // ST mem[r[Rb] + d] <- r[Ra]
                alusrc1_s  = 1'b1;
                alusrc2_s  = 1'b1;
                as_bc_s    = 1'b1;
                memwrite_s = 1'b1;
                imm_s      = ir_r[7:0];
                use_ra_s   = 1'b1;
                use_rb_s   = 1'b1;
            end
            2'b10: begin
                case (op2_s)
                    3'b000: begin   // LI r[Rb] <- sext(d)
                        sli_s      = 1'b1;
                        alusrc2_s  = 1'b1;
                        regwrite_s = 1'b1;
                        imm_s      = ir_r[7:0];
                    end
                    3'b100: begin   // B
                        br_en_s    = 1'b1;
                        br_cond_s  = 3'b100;
                        imm_s      = ir_r[7:0];
                    end
                    3'b111: begin   // Bcc; undefined conditions behave as NOP
                        if (ir_r[10:8] <= 3'b011) begin
                            br_en_s   = 1'b1;
                            br_cond_s = ir_r[10:8];
                            imm_s     = ir_r[7:0];
                        end else begin
                            br_en_s   = 1'b0;
                        end
                    end
                    default: begin
                        br_en_s    = 1'b0;
                    end
                endcase
            end
            default: begin
                br_en_s    = 1'b0;
            end
        endcase
    end

    assign is_hlt_s = (op1_s == 2'b11) && (op3_s == 4'b1111);

    // Load-use hazard: the LD in phase 3 writes a register this instruction reads.
    always_comb begin
        stall_s = 1'b0;
        if (irv_r && !flush && (state_r == ST_RUN) && ex_memread) begin
            stall_s = (use_ra_s && (ir_r[13:11] == ex_rd)) ||
                      (use_rb_s && (ir_r[10:8]  == ex_rd));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign bubble_s = !irv_r || stall_s || flush || (state_r == ST_HALTED);

    // IF/ID register: reset, then flush, halt, stall and normal capture in priority order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_r   <= 16'h0000;
            irpc_r <= 16'h0000;
            irv_r  <= 1'b0;
        end else if (flush) begin
            irv_r  <= 1'b0;
        end else if (state_r == ST_HALTED) begin
            irv_r  <= 1'b0;
        end else if (stall_s) begin
            ir_r   <= ir_r;
            irpc_r <= irpc_r;
            irv_r  <= irv_r;
        end else begin
            ir_r   <= inst;
            irpc_r <= pc_in;
            irv_r  <= inst_valid;
        end
    end

    // Run/halt FSM: a valid, unflushed HLT in decode halts until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (irv_r && is_hlt_s && !stall_s && !flush) begin
                        state_r <= ST_HALTED;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HALTED: state_r <= ST_HALTED;
                default:   state_r <= ST_RUN;
            endcase
        end
    end

    assign dvalid       = !bubble_s;
    assign ALUSrc1      = alusrc1_s  & !bubble_s;
    assign ALUSrc2      = alusrc2_s  & !bubble_s;
    assign ALUorshifter = shifter_s  & !bubble_s;
    assign AS_BC        = as_bc_s    & !bubble_s;
    assign MemRead      = memread_s  & !bubble_s;
    assign MemWrite     = memwrite_s & !bubble_s;
    assign RegWrite     = regwrite_s & !bubble_s;
    assign SLI          = sli_s      & !bubble_s;
    assign br_en        = br_en_s    & !bubble_s;
    assign br_cond      = bubble_s ? 3'b000   : br_cond_s;
    assign opcode       = bubble_s ? 4'b0000  : opcode_s;
    assign imm          = bubble_s ? 8'h00    : imm_s;
    assign Ra           = ir_r[13:11];
    assign Rb           = ir_r[10:8];
    assign pc_out       = irpc_r;
    assign halted       = (state_r == ST_HALTED);
    assign hold         = stall_s | (state_r == ST_HALTED);

endmodule

// File: tb/tb_phase2dec.sv
// Directed testbench for phase2dec.
module tb_phase2dec;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic [15:0] pc_in;
    logic        inst_valid;
    logic        flush;
    logic        ex_memread;
    logic [2:0]  ex_rd;
    logic        ALUSrc1, ALUSrc2, ALUorshifter, AS_BC;
    logic        MemRead, MemWrite, RegWrite, SLI;
    logic [2:0]  Ra, Rb;
    logic [3:0]  opcode;
    logic [7:0]  imm;
    logic        br_en;
    logic [2:0]  br_cond;
    logic [15:0] pc_out;
    logic        dvalid, hold, halted;

    int pass_cnt;
    int total_cnt;

    // Control bundle: {ALUSrc1,ALUSrc2,ALUorshifter,AS_BC,MemRead,MemWrite,RegWrite,SLI,br_en,br_cond,opcode,imm}
    logic [23:0] ctl;
    assign ctl = {ALUSrc1, ALUSrc2, ALUorshifter, AS_BC, MemRead, MemWrite,
                  RegWrite, SLI, br_en, br_cond, opcode, imm};

    phase2dec dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .pc_in(pc_in),
        .inst_valid(inst_valid), .flush(flush), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .ALUorshifter(ALUorshifter), .AS_BC(AS_BC), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .SLI(SLI), .Ra(Ra), .Rb(Rb),
        .opcode(opcode), .imm(imm), .br_en(br_en), .br_cond(br_cond),
        .pc_out(pc_out), .dvalid(dvalid), .hold(hold), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst = 16'hD100; pc_in = 16'h0040; inst_valid = 1'b1;
        flush = 1'b0; ex_memread = 1'b0; ex_rd = 3'd0;
        tick(); tick();
        total_cnt++;
        if ({dvalid, hold, halted} !== 3'b000) $display("FAIL reset_status: got %b want 000", {dvalid, hold, halted});
        else pass_cnt++;
        total_cnt++;
        if (ctl !== 24'h000000) $display("FAIL reset_ctl: got %h want 000000", ctl);
        else pass_cnt++;
        total_cnt++;
        if ({Ra, Rb, pc_out} !== {3'd0, 3'd0, 16'h0000}) $display("FAIL reset_fields: got %h want 0", {Ra, Rb, pc_out});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [23:0] exp;
        inst = 16'hD100; pc_in = 16'h0010; inst_valid = 1'b1;
        tick();
        exp = {9'b100100100, 3'b000, 4'b0000, 8'h00};
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, exp}) $display("FAIL add_ctl: got %b_%h want 1_%h", dvalid, ctl, exp);
        else pass_cnt++;
        total_cnt++;
        if ({Ra, Rb, pc_out} !== {3'd2, 3'd1, 16'h0010}) $display("FAIL add_fields: got %0d %0d %h want 2 1 0010", Ra, Rb, pc_out);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [23:0] exp;
        inst = 16'hD900; pc_in = 16'h0011; inst_valid = 1'b1;
        tick();
        inst = 16'hD560; pc_in = 16'h0012;
        ex_memread = 1'b1; ex_rd = 3'd3;
        #1;
        total_cnt++;
        if ({hold, dvalid, ctl} !== {2'b10, 24'h000000}) $display("FAIL stall_ra: got %b_%b_%h want 1_0_000000", hold, dvalid, ctl);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({hold, Ra, pc_out} !== {1'b1, 3'd3, 16'h0011}) $display("FAIL stall_held: got %b %0d %h want 1 3 0011", hold, Ra, pc_out);
        else pass_cnt++;
        ex_rd = 3'd1;
        #1;
        total_cnt++;
        if ({hold, dvalid} !== 2'b10) $display("FAIL stall_rb: got %b want 10", {hold, dvalid});
        else pass_cnt++;
        ex_rd = 3'd5;
        #1;
        exp = {9'b100100100, 3'b000, 4'b0000, 8'h00};
        total_cnt++;
        if ({hold, dvalid, ctl} !== {2'b01, exp}) $display("FAIL nostall_rd5: got %b_%b_%h want 0_1_%h", hold, dvalid, ctl, exp);
        else pass_cnt++;
        ex_memread = 1'b0; ex_rd = 3'd3;
        #1;
        total_cnt++;
        if ({hold, dvalid, RegWrite} !== 3'b011) $display("FAIL stall_release: got %b want 011", {hold, dvalid, RegWrite});
        else pass_cnt++;
        tick();
        exp = {9'b000100100, 3'b000, 4'b0000, 8'h00};
        total_cnt++;
        if ({dvalid, ctl, pc_out} !== {1'b1, exp, 16'h0012}) $display("FAIL mov_ctl: got %b_%h_%h want 1_%h_0012", dvalid, ctl, pc_out, exp);
        else pass_cnt++;
        ex_memread = 1'b1; ex_rd = 3'd5;
        #1;
        total_cnt++;
        if (hold !== 1'b0) $display("FAIL mov_rb_nostall: got %b want 0", hold);
        else pass_cnt++;
        ex_rd = 3'd2;
        #1;
        total_cnt++;
        if (hold !== 1'b1) $display("FAIL mov_ra_stall: got %b want 1", hold);
        else pass_cnt++;
        ex_memread = 1'b0;
    endtask

    task automatic test_li_shift();
        logic [23:0] exp;
        inst = 16'h82FF; pc_in = 16'h0013; inst_valid = 1'b1;
        tick();
        exp = {9'b010000110, 3'b000, 4'b0000, 8'hFF};
        total_cnt++;
        if ({dvalid, ctl, Rb} !== {1'b1, exp, 3'd2}) $display("FAIL li_ctl: got %b_%h_%0d want 1_%h_2", dvalid, ctl, Rb, exp);
        else pass_cnt++;
        inst = 16'hC4B3; pc_in = 16'h0014;
        tick();
        exp = {9'b101000100, 3'b000, 4'b1011, 8'h03};
        total_cnt++;
        if ({dvalid, ctl, Rb} !== {1'b1, exp, 3'd4}) $display("FAIL sra_ctl: got %b_%h_%0d want 1_%h_4", dvalid, ctl, Rb, exp);
        else pass_cnt++;
        ex_memread = 1'b1; ex_rd = 3'd0;
        #1;
        total_cnt++;
        if (hold !== 1'b0) $display("FAIL shift_ra_nostall: got %b want 0", hold);
        else pass_cnt++;
        ex_rd = 3'd4;
        #1;
        total_cnt++;
        if (hold !== 1'b1) $display("FAIL shift_rb_stall: got %b want 1", hold);
        else pass_cnt++;
        ex_memread = 1'b0;
    endtask

    task automatic test_mem();
        logic [23:0] exp;
        inst = 16'h0A05; pc_in = 16'h0015; inst_valid = 1'b1;
        tick();
        exp = {9'b110110100, 3'b000, 4'b0000, 8'h05};
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, exp}) $display("FAIL ld_ctl: got %b_%h want 1_%h", dvalid, ctl, exp);
        else pass_cnt++;
        inst = 16'h4A05; pc_in = 16'h0016;
        tick();
        exp = {9'b110101000, 3'b000, 4'b0000, 8'h05};
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, exp}) $display("FAIL st_ctl: got %b_%h want 1_%h", dvalid, ctl, exp);
        else pass_cnt++;
        inst = 16'h0000; inst_valid = 1'b0;
        tick();
        total_cnt++;
        if ({dvalid, MemRead} !== 2'b00) $display("FAIL zero_invalid: got %b want 00", {dvalid, MemRead});
        else pass_cnt++;
    endtask

    task automatic test_flush();
        inst = 16'hD100; pc_in = 16'h0020; inst_valid = 1'b1;
        tick();
        flush = 1'b1; ex_memread = 1'b1; ex_rd = 3'd2;
        inst = 16'hD900; pc_in = 16'h0021;
        #1;
        total_cnt++;
        if ({dvalid, RegWrite, hold, Ra} !== {3'b000, 3'd2}) $display("FAIL flush_now: got %b want 000010", {dvalid, RegWrite, hold, Ra});
        else pass_cnt++;
        tick();
        flush = 1'b0; ex_memread = 1'b0;
        #1;
        total_cnt++;
        if ({dvalid, ctl} !== {1'b0, 24'h000000}) $display("FAIL flush_next: got %b_%h want 0_000000", dvalid, ctl);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dvalid, RegWrite, pc_out} !== {2'b11, 16'h0021}) $display("FAIL flush_recover: got %b_%b_%h want 1_1_0021", dvalid, RegWrite, pc_out);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        logic [23:0] exp;
        inst = 16'hBB10; pc_in = 16'h0022; inst_valid = 1'b1;
        tick();
        exp = {9'b000000001, 3'b011, 4'b0000, 8'h10};
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, exp}) $display("FAIL bne_ctl: got %b_%h want 1_%h", dvalid, ctl, exp);
        else pass_cnt++;
        inst = 16'hA005; pc_in = 16'h0023;
        tick();
        exp = {9'b000000001, 3'b100, 4'b0000, 8'h05};
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, exp}) $display("FAIL b_ctl: got %b_%h want 1_%h", dvalid, ctl, exp);
        else pass_cnt++;
        inst = 16'hBD00; pc_in = 16'h0024;
        tick();
        total_cnt++;
        if ({dvalid, ctl} !== {1'b1, 24'h000000}) $display("FAIL bcc_nop: got %b_%h want 1_000000", dvalid, ctl);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        inst = 16'hC0F0; pc_in = 16'h0030; inst_valid = 1'b1;
        tick();
        total_cnt++;
        if ({dvalid, halted, hold, ctl} !== {3'b100, 24'h000000}) $display("FAIL hlt_cycle: got %b_%h want 100_000000", {dvalid, halted, hold}, ctl);
        else pass_cnt++;
        inst = 16'hD100; pc_in = 16'h0031;
        tick();
        total_cnt++;
        if ({dvalid, halted, hold, ctl} !== {3'b011, 24'h000000}) $display("FAIL halted_1: got %b_%h want 011_000000", {dvalid, halted, hold}, ctl);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({dvalid, halted, hold, RegWrite} !== 4'b0110) $display("FAIL halted_2: got %b want 0110", {dvalid, halted, hold, RegWrite});
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if ({dvalid, halted, hold, pc_out} !== {3'b000, 16'h0000}) $display("FAIL halt_reset: got %b_%h want 000_0000", {dvalid, halted, hold}, pc_out);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({dvalid, RegWrite, pc_out} !== {2'b11, 16'h0031}) $display("FAIL post_reset_run: got %b_%h want 11_0031", {dvalid, RegWrite}, pc_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_add();
        test_stall();
        test_li_shift();
        test_mem();
        test_flush();
        test_branch();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
